// File: rtl/idma_rd_fifo_arb.sv
// Round-robin drain of per-channel iDMA read FIFOs onto one tagged outbound stream,
// with bounded bursts and a global FIFO flush sequence.
//
// state       | meaning
// IDLE        | arbitrate across channels, or start a flush
// GRANT       | pop the granted channel until the burst fills or the channel runs dry
// FLUSH_DRAIN | wait for the held output beat to leave, then strobe ch_init
// FLUSH_DONE  | pulse flush_done and restart round-robin from channel 0
module idma_rd_fifo_arb #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 8,
    parameter int CH_ID_W   = 2,
    parameter int BCNT_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [N_CH-1:0]          ch_pop,
    output logic                     ch_init,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_ID_W-1:0]       out_ch_id,
    output logic                     out_last,
    input  logic                     out_ready,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, GRANT, FLUSH_DRAIN, FLUSH_DONE} state_t;

    state_t               state;
    logic [CH_ID_W-1:0]   rr_ptr;
    logic [CH_ID_W-1:0]   grant_id;
    logic [CH_ID_W-1:0]   next_id;
    logic [CH_ID_W-1:0]   grant_nxt;
    logic [BCNT_W-1:0]    burst_cnt;
    logic                 any_valid;
    logic                 load_ok;
    logic                 pop;
    logic                 burst_end;
    logic                 release_grant;

    // Scan from the highest offset down so the channel closest to rr_ptr wins.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        next_id   = '0;
        idx       = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (ch_valid[idx]) begin
                any_valid = 1'b1;
                next_id   = CH_ID_W'(idx);
            end
        end
    end

    assign load_ok       = !out_valid || out_ready;
    assign pop           = (state == GRANT) && ch_valid[grant_id] && load_ok;
    assign burst_end     = (burst_cnt == BCNT_W'(MAX_BURST - 1));
    assign release_grant = (pop && burst_end) || (!ch_valid[grant_id] && load_ok);
    assign grant_nxt     = (grant_id == CH_ID_W'(N_CH - 1)) ? '0 : grant_id + CH_ID_W'(1);
    assign busy          = (state != IDLE);

    always_comb begin
        ch_pop = '0;
        if (pop) ch_pop[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            burst_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch_id  <= '0;
            out_last   <= 1'b0;
            ch_init    <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            ch_init    <= 1'b0;
            flush_done <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_id*DATA_W +: DATA_W];
                out_ch_id <= grant_id;
                out_last  <= burst_end;
                burst_cnt <= burst_cnt + BCNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH_DRAIN;
                    end else if (any_valid) begin
                        grant_id  <= next_id;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // A pending flush waits for the burst to end; it never cuts one short.
                    if (release_grant) begin
                        rr_ptr <= grant_nxt;
                        state  <= flush_req ? FLUSH_DRAIN : IDLE;
                    end
                end
                FLUSH_DRAIN: begin
                    if (!out_valid) begin
                        ch_init <= 1'b1;
                        state   <= FLUSH_DONE;
                    end
                end
                FLUSH_DONE: begin
                    flush_done <= 1'b1;
                    rr_ptr     <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idma_rd_fifo_arb.sv
// Directed bench for idma_rd_fifo_arb: behavioural per-channel FIFO occupancy model
// feeds the arbiter; each scenario checks hand-derived beats, pops and flush strobes.
module tb_idma_rd_fifo_arb;

    localparam int N_CH      = 4;
    localparam int DATA_W    = 128;
    localparam int MAX_BURST = 8;
    localparam int CH_ID_W   = 2;
    localparam int BCNT_W    = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        ch_valid;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_pop;
    logic                   ch_init;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [CH_ID_W-1:0]     out_ch_id;
    logic                   out_last;
    logic                   out_ready;
    logic                   flush_req;
    logic                   flush_done;
    logic                   busy;

    int n_vec = 0;
    int n_bad = 0;
    int avail [N_CH];
    int seq   [N_CH];

    idma_rd_fifo_arb #(
        .N_CH(N_CH), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST),
        .CH_ID_W(CH_ID_W), .BCNT_W(BCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_pop(ch_pop), .ch_init(ch_init), .out_valid(out_valid),
        .out_data(out_data), .out_ch_id(out_ch_id), .out_last(out_last),
        .out_ready(out_ready), .flush_req(flush_req), .flush_done(flush_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] beat_val(input int ch, input int s);
        return {64'h0, 32'hA5A5_0000 + 32'(ch), 32'(s)};
    endfunction

    task automatic drive_ch();
        for (int i = 0; i < N_CH; i++) begin
            ch_valid[i] = (avail[i] != 0);
            ch_data[i*DATA_W +: DATA_W] = beat_val(i, seq[i]);
        end
    endtask

    // One clock: sample pop/init away from the edge, then advance the FIFO model.
    task automatic step();
        logic [N_CH-1:0] p;
        logic            ci;
        @(negedge clk);
        p  = ch_pop;
        ci = ch_init;
        n_vec++;
        if (!$onehot0(p) || (ci && (p != '0))) begin
            n_bad++;
            $display("FAIL pop_invariant: ch_pop=%b ch_init=%b, required one-hot-or-zero and no pop with init", p, ci);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (ci) begin
                avail[i] = 0;
                seq[i]   = 0;
            end else if (p[i]) begin
                avail[i] = avail[i] - 1;
                seq[i]   = seq[i] + 1;
            end
        end
        drive_ch();
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        out_ready = 1'b1;
        flush_req = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            avail[i] = 0;
            seq[i]   = 0;
        end
        drive_ch();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [DATA_W+N_CH+7:0] got;
        reset_dut();
        got = {out_valid, out_last, out_ch_id, out_data, ch_pop, ch_init, flush_done, busy};
        n_vec++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, expected all zero", got);
        end
        step();
        n_vec++;
        if ({out_valid, busy, ch_pop} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got valid=%b busy=%b pop=%b, expected 0 0 0000", out_valid, busy, ch_pop);
        end
    endtask

    task automatic test_single_ch();
        logic [DATA_W+3:0] got, exp;
        reset_dut();
        avail[0] = 8;
        drive_ch();
        #1;
        n_vec++;
        if (ch_pop !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_no_pop_idle: got %b, expected 0000", ch_pop);
        end
        step();
        n_vec++;
        if (ch_pop !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_first_pop: got %b, expected 0001", ch_pop);
        end
        for (int b = 0; b < 8; b++) begin
            step();
            got = {out_valid, out_ch_id, out_last, out_data};
            exp = {1'b1, 2'd0, (b == 7), beat_val(0, b)};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL single_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_release: busy=%b, expected 0", busy);
        end
        avail[0] = 3;
        avail[1] = 3;
        drive_ch();
        step();
        n_vec++;
        if (ch_pop !== 4'b0010) begin
            n_bad++;
            $display("FAIL single_rr_next: got %b, expected 0010", ch_pop);
        end
    endtask

    task automatic test_fairness();
        logic [DATA_W+3:0] got, exp;
        logic [N_CH-1:0]   pexp;
        reset_dut();
        for (int i = 0; i < N_CH; i++) avail[i] = 100;
        drive_ch();
        for (int g = 0; g < 5; g++) begin
            step();
            pexp = 4'b0001 << (g % 4);
            n_vec++;
            if ({out_valid, ch_pop} !== {1'b0, pexp}) begin
                n_bad++;
                $display("FAIL rr_arb%0d: got valid=%b pop=%b, expected 0 %b", g, out_valid, ch_pop, pexp);
            end
            for (int b = 0; b < 8; b++) begin
                step();
                got = {out_valid, out_ch_id, out_last, out_data};
                exp = {1'b1, 2'(g % 4), (b == 7), beat_val(g % 4, (g / 4) * 8 + b)};
                n_vec++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL rr_g%0d_beat%0d: got %h, expected %h", g, b, got, exp);
                end
            end
        end
    endtask

    task automatic test_early_release();
        logic [DATA_W+3:0] got, exp;
        reset_dut();
        avail[2] = 3;
        avail[3] = 100;
        drive_ch();
        step();
        n_vec++;
        if (ch_pop !== 4'b0100) begin
            n_bad++;
            $display("FAIL early_first_grant: got %b, expected 0100", ch_pop);
        end
        for (int b = 0; b < 3; b++) begin
            step();
            got = {out_valid, out_ch_id, out_last, out_data};
            exp = {1'b1, 2'd2, 1'b0, beat_val(2, b)};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL early_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        step();
        n_vec++;
        if ({out_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL early_release: got valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
        step();
        n_vec++;
        if (ch_pop !== 4'b1000) begin
            n_bad++;
            $display("FAIL early_next_grant: got %b, expected 1000", ch_pop);
        end
        step();
        got = {out_valid, out_ch_id, out_last, out_data};
        exp = {1'b1, 2'd3, 1'b0, beat_val(3, 0)};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL early_ch3_beat: got %h, expected %h", got, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W+3:0] got, exp;
        logic [DATA_W+5:0] sgot, sexp;
        reset_dut();
        avail[1] = 100;
        drive_ch();
        step();
        for (int b = 0; b < 3; b++) begin
            step();
            got = {out_valid, out_ch_id, out_last, out_data};
            exp = {1'b1, 2'd1, 1'b0, beat_val(1, b)};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL bp_pre_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            sgot = {out_valid, ch_pop, out_last, out_data};
            sexp = {1'b1, 4'b0000, 1'b0, beat_val(1, 2)};
            n_vec++;
            if (sgot !== sexp) begin
                n_bad++;
                $display("FAIL bp_stall%0d: got %h, expected %h", k, sgot, sexp);
            end
        end
        out_ready = 1'b1;
        for (int b = 3; b < 8; b++) begin
            step();
            got = {out_valid, out_ch_id, out_last, out_data};
            exp = {1'b1, 2'd1, (b == 7), beat_val(1, b)};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL bp_post_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic [DATA_W+3:0] got, exp;
        reset_dut();
        avail[1] = 100;
        drive_ch();
        step();
        for (int b = 0; b < 8; b++) begin
            step();
            got = {out_valid, out_ch_id, out_last, out_data};
            exp = {1'b1, 2'd1, (b == 7), beat_val(1, b)};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL flush_beat%0d: got %h, expected %h", b, got, exp);
            end
            if (b == 3) flush_req = 1'b1;
        end
        step();
        n_vec++;
        if ({out_valid, ch_init, busy, ch_pop} !== 7'b0010000) begin
            n_bad++;
            $display("FAIL flush_drain: got valid=%b init=%b busy=%b pop=%b, expected 0 0 1 0000", out_valid, ch_init, busy, ch_pop);
        end
        step();
        n_vec++;
        if ({ch_init, flush_done, ch_pop} !== 6'b100000) begin
            n_bad++;
            $display("FAIL flush_init: got init=%b done=%b pop=%b, expected 1 0 0000", ch_init, flush_done, ch_pop);
        end
        step();
        n_vec++;
        if ({ch_init, flush_done, busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL flush_done: got init=%b done=%b busy=%b, expected 0 1 0", ch_init, flush_done, busy);
        end
        flush_req = 1'b0;
        avail[0]  = 2;
        avail[3]  = 2;
        drive_ch();
        step();
        n_vec++;
        if ({flush_done, ch_pop} !== 5'b00001) begin
            n_bad++;
            $display("FAIL flush_rr_zero: got done=%b pop=%b, expected 0 0001", flush_done, ch_pop);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DATA_W+3:0] got, exp;
        reset_dut();
        avail[2] = 3;
        avail[3] = 100;
        drive_ch();
        for (int k = 0; k < 7; k++) step();
        step();
        got = {out_valid, out_ch_id, out_last, out_data};
        exp = {1'b1, 2'd3, 1'b0, beat_val(3, 1)};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL rstmid_setup_beat: got %h, expected %h", got, exp);
        end
        out_ready = 1'b0;
        step();
        n_vec++;
        if ({out_valid, ch_pop} !== 5'b10000) begin
            n_bad++;
            $display("FAIL rstmid_stall: got valid=%b pop=%b, expected 1 0000", out_valid, ch_pop);
        end
        rst = 1'b1;
        step();
        n_vec++;
        if ({out_valid, ch_pop, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL rstmid_cleared: got valid=%b pop=%b busy=%b, expected 0 0000 0", out_valid, ch_pop, busy);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        avail[0]  = 4;
        drive_ch();
        step();
        n_vec++;
        if (ch_pop !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstmid_regrant: got %b, expected 0001", ch_pop);
        end
        step();
        got = {out_valid, out_ch_id, out_last, out_data};
        exp = {1'b1, 2'd0, 1'b0, beat_val(0, 0)};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL rstmid_first_beat: got %h, expected %h", got, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        flush_req = 1'b0;
        ch_valid  = '0;
        ch_data   = '0;
        test_reset();
        test_single_ch();
        test_fairness();
        test_early_release();
        test_backpressure();
        test_flush();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
